// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the RV32I store port.
// A store to TXDATA queues one byte. A store to CTRL with bit0 set clears the
// sticky overflow flag. The status word is read back combinationally from CTRL.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [31:0] data_address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]       CTRL_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    // Serializer state
    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_busy;

    // Combinational next values
    state_t            w_state_next;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        w_idx_next;
    logic [7:0]        w_shift_next;
    logic              w_tx_next;
    logic              w_pop;

    logic       w_aligned;
    logic       w_sel_tx;
    logic       w_sel_ctrl;
    logic       w_push_ok;
    logic       w_push_drop;
    logic       w_empty;
    logic       w_full;
    logic [7:0] w_head;

    // Address decode: full 32-bit compare, word-aligned addresses only
    assign w_aligned  = (data_address[1:0] == 2'b00);
    assign w_sel_tx   = write_enable && w_aligned && (data_address == BASE_ADDR);
    assign w_sel_ctrl = write_enable && w_aligned && (data_address == CTRL_ADDR);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_head  = r_mem[r_rd_ptr];

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands
    assign w_push_ok   = w_sel_tx && (!w_full || w_pop);
    assign w_push_drop = w_sel_tx && !w_push_ok;

    // FIFO data array, no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= write_data[7:0];
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end else if (w_sel_ctrl && write_data[0]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Serializer state register; reset drives the line high at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    // Serializer next-state logic; every bit lasts CLKS_PER_BIT cycles
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_shift_next = w_head;
                    w_baud_next  = BAUD_LOAD;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (r_baud == '0) begin
                    w_state_next = S_DATA;
                    w_baud_next  = BAUD_LOAD;
                    w_idx_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_baud_next = r_baud - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (r_baud == '0) begin
                    w_baud_next = BAUD_LOAD;
                    if (r_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_tx_next    = r_shift[1];
                        w_idx_next   = r_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud - BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (r_baud == '0) begin
                    if (!w_empty) begin
                        // Chain straight into the next frame with no idle gap
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                        w_shift_next = w_head;
                        w_baud_next  = BAUD_LOAD;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud - BAUD_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign fifo_full = w_full;
    assign overflow  = r_overflow;

    // Status readback: {overflow, full, empty, busy} at the CTRL address only
    assign read_data = (data_address == CTRL_ADDR)
                     ? {28'b0, r_overflow, w_full, w_empty, r_busy}
                     : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE 0x100).
module tb_mmio_uart_tx;

    logic        clk;
    logic        reset;
    logic        write_enable;
    logic [31:0] data_address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (32'h0000_0100),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_enable(write_enable),
        .data_address(data_address),
        .write_data  (write_data),
        .read_data   (read_data),
        .tx          (tx),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        write_enable = 1'b1;
        data_address = addr;
        write_data   = data;
        cycle();
        write_enable = 1'b0;
        data_address = 32'h0;
        write_data   = 32'h0;
        $display("store addr=0x%08h data=0x%08h", addr, data);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] exp);
        data_address = 32'h104;
        #1;
        chk(tag, read_data, exp);
        data_address = 32'h0;
    endtask

    // Expects to be at frame cycle 0; checks every cycle of nfr frames, then idle
    task automatic expect_frames(input logic [7:0] b0, input logic [7:0] b1,
                                 input int nfr, input string tag);
        logic [7:0] b;
        int         j;
        logic       e;
        for (int k = 0; k < nfr * 40; k++) begin
            if (k > 0) cycle();
            b = (k < 40) ? b0 : b1;
            j = (k % 40) / 4;
            if (j == 0)      e = 1'b0;
            else if (j == 9) e = 1'b1;
            else             e = b[j-1];
            chk($sformatf("%s_tx_k%0d", tag, k), {31'b0, tx}, {31'b0, e});
            chk($sformatf("%s_busy_k%0d", tag, k), {31'b0, busy}, 32'd1);
        end
        cycle();
        chk($sformatf("%s_busy_end", tag), {31'b0, busy}, 32'd0);
        chk($sformatf("%s_tx_end", tag), {31'b0, tx}, 32'd1);
        $display("frames %s bytes=0x%02h,0x%02h count=%0d", tag, b0, b1, nfr);
    endtask

    initial begin
        int m;
        reset        = 1'b1;
        write_enable = 1'b0;
        data_address = 32'h0;
        write_data   = 32'h0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Reset state
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_full", {31'b0, fifo_full}, 32'd0);
        rd_chk("rst_status", 32'h2);
        data_address = 32'h100;
        #1;
        chk("rd_other_addr", read_data, 32'h0);
        data_address = 32'h0;

        // Single frame 0x55: queued but not yet started right after the store
        wr(32'h100, 32'h0000_0055);
        chk("s55_tx_pre", {31'b0, tx}, 32'd1);
        rd_chk("s55_status_pre", 32'h0);
        cycle();
        expect_frames(8'h55, 8'h00, 1, "s55");

        // Two back-to-back frames, upper store bits ignored
        wr(32'h100, 32'hDEAD_BEA3);
        wr(32'h100, 32'h0000_000F);
        expect_frames(8'hA3, 8'h0F, 2, "a3_0f");

        // Ten stores: nine accepted, tenth dropped
        for (int i = 0; i < 10; i++) begin
            wr(32'h100, 32'(i));
        end
        chk("burst_full", {31'b0, fifo_full}, 32'd1);
        chk("burst_ovf", {31'b0, overflow}, 32'd1);
        rd_chk("burst_status", 32'hD);
        wr(32'h104, 32'h0000_0001);
        chk("ovf_cleared", {31'b0, overflow}, 32'd0);
        rd_chk("clr_status", 32'h5);
        m = 0;
        while (busy && m < 1000) begin
            cycle();
            m++;
        end
        chk("drain_done", {31'b0, busy}, 32'd0);
        chk("drain_cycles", 32'(m), 32'd351);
        rd_chk("drain_status", 32'h2);

        // Unaligned and unmapped stores do nothing
        wr(32'h101, 32'h0000_00FF);
        wr(32'h200, 32'h0000_00FF);
        rd_chk("nomatch_status", 32'h2);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("nomatch_tx_%0d", k), {31'b0, tx}, 32'd1);
            chk($sformatf("nomatch_busy_%0d", k), {31'b0, busy}, 32'd0);
        end

        // Reset during data bit 4 with three bytes queued
        wr(32'h100, 32'h0000_0000);
        wr(32'h100, 32'h0000_0011);
        wr(32'h100, 32'h0000_0022);
        wr(32'h100, 32'h0000_0033);
        for (int k = 0; k < 19; k++) cycle();
        chk("mid_tx_bit4", {31'b0, tx}, 32'd0);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rd_chk("mid_status", 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_tx", {31'b0, tx}, 32'd1);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_full", {31'b0, fifo_full}, 32'd0);
        rd_chk("arst_status", 32'h2);
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            chk($sformatf("post_rst_tx_%0d", k), {31'b0, tx}, 32'd1);
            chk($sformatf("post_rst_busy_%0d", k), {31'b0, busy}, 32'd0);
        end
        rd_chk("post_rst_status", 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the single-cycle RV32I core's data-store port and consumes its `write_enable` / `data_address` / `write_data` outputs. Store words addressed to its TX register are buffered in a small FIFO and serialized as 8N1 frames, LSB first. A status register is returned on `read_data` so the core can poll `full` and `busy` before storing.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0100: byte address of the TXDATA register. CTRL/STATUS is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit. Must be ≥2.
- `FIFO_DEPTH`, 8: FIFO entries. Must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `write_enable`  in  1  store strobe from the core.
- `data_address`  in  32  store/load byte address from the core.
- `write_data`  in  32  store data from the core.
- `read_data`  out  32  combinational status readback.
- `tx`  out  1  serial line, registered, idle-high.
- `busy`  out  1  serializer not in IDLE, registered.
- `fifo_full`  out  1  FIFO count == `FIFO_DEPTH`.
- `overflow`  out  1  sticky flag: a push was dropped.

## Operation
- Address decode uses a full 32-bit compare. Addresses with `data_address[1:0]` ≠ 0 never match. Writes to any other address are ignored.
- Write to TXDATA: pushes `write_data[7:0]`. Upper bits are ignored.
- Write to CTRL: if `write_data[0]`=1, `overflow` is cleared. Other bits are ignored.
- `read_data`: equals `{28'b0, overflow, fifo_full, fifo_empty, busy}` when `data_address == BASE_ADDR+4`, otherwise 0.
- FIFO:
  - Circular buffer with read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap naturally.
  - Count is `$clog2(FIFO_DEPTH+1)` bits.
  - A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the push is dropped and `overflow` is set.
  - Simultaneous push and pop leaves count unchanged.
- Serializer FSM:
  - States: IDLE, START, DATA, STOP.
  - A baud counter counts `CLKS_PER_BIT-1` down to 0.
  - A 3-bit bit index and an 8-bit shift register hold the frame.
  - IDLE → START: when the FIFO is non-empty. On that edge, pop the head into the shift register, load the baud counter, and set `tx`=0.
  - START → DATA: on baud counter = 0. Set `tx`=shift[0] and index=0.
  - DATA: on baud counter = 0, shift right and output the next bit. After index 7 expires, go to STOP with `tx`=1.
  - STOP → START: on baud counter = 0, if the FIFO is non-empty. Pop on the same edge; there is no idle gap.
  - STOP → IDLE: on baud counter = 0, if the FIFO is empty.
- Reset (asynchronous, any time including mid-frame):
  - `tx`=1, state=IDLE, `busy`=0.
  - FIFO emptied, pointers=0, `overflow`=0.
  - `fifo_full`=0, `read_data` reflects empty=1.
  - A partial frame is abandoned; the line returns high immediately.

## Timing
- Push at edge N: count increments at N. If the FSM is IDLE, the pop and `tx`=0 happen at edge N+1. Write-to-start-bit latency is 1 cycle.
- Each bit holds for exactly `CLKS_PER_BIT` cycles. A frame is 10·`CLKS_PER_BIT` cycles.
- `busy` rises with the start bit. It falls at the end of the stop bit, at the edge entering IDLE.
- Back-to-back frames: the next start bit begins on the edge after the last stop-bit cycle.
- `fifo_full` and `overflow` update on the edge of the causing write. `read_data` follows the registered flags with no added latency.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `FIFO_DEPTH`=8, `BASE_ADDR`=0x100.
- Reset pulse mid-idle: `tx`=1, `busy`=0, `overflow`=0. Read of 0x104 returns 0x2.
- Store 0x55 to 0x100: starting 1 cycle later, `tx` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `busy` is high for exactly 40 cycles.
- Store 0xA3 then 0x0F on consecutive cycles: two frames with no idle cycle between them. Total `busy` = 80 cycles. Bit order is LSB first.
- Store 10 bytes on consecutive cycles:
  - The first byte pops at cycle 2, so 9 are accepted.
  - The 10th is dropped and `overflow`=1; read of 0x104 shows bit3=1.
  - Storing 1 to 0x104 clears bit3.
- Store 0xFF to 0x101 and to 0x200: no FIFO change, `tx` stays 1.
- Assert `reset` during bit 4 of a frame with 3 bytes queued: `tx`=1 immediately, FIFO empty, and no further frames are sent.
